// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer for VGA_Printer: pixel tick, h/v timing, pixel address, RGB/sync alignment, per-frame game snapshot.
// Optional colour bars: define VGA_TEST_PATTERN_EN (adds the test_mode input).
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         CLK_100MHz,
  input  logic         RST,
`ifdef VGA_TEST_PATTERN_EN
  input  logic         test_mode,
`endif
  input  logic [3:0]   game_state,
  input  logic [323:0] game_map,
  input  logic [7:0]   game_select,
  input  logic [80:0]  game_ro,
  output logic [18:0]  pix_addr,
  output logic [3:0]   state,
  output logic [323:0] cur_map,
  output logic [7:0]   cur_select,
  output logic [80:0]  read_only,
  input  logic [3:0]   pix_R_in,
  input  logic [3:0]   pix_G_in,
  input  logic [3:0]   pix_B_in,
  output logic [3:0]   vga_R,
  output logic [3:0]   vga_G,
  output logic [3:0]   vga_B,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_reg;
  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;
  logic          tick, active_next, hs_next, vs_next, snap_fire;
  logic [18:0]   addr_next;
  logic          active0_reg, hs0_reg, vs0_reg;
  logic [3:0]    r_sel, g_sel, b_sel;

  assign tick = (div_reg == DIV_LAST);

  always_comb begin
    h_next = h_reg + 1'b1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
    end
  end

  // Stage 0 is computed from the position the counters are about to take.
  assign active_next = (h_next < H_ACT) && (v_next < V_ACT);
  assign addr_next   = active_next ? (19'(v_next) * 19'(H_ACTIVE) + 19'(h_next)) : '0;
  assign hs_next     = !((h_next >= HS_BEG) && (h_next < HS_END));
  assign vs_next     = !((v_next >= VS_BEG) && (v_next < VS_END));
  assign snap_fire   = tick && (h_next == '0) && (v_next == V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  logic [15:0] h_wide;
  logic [2:0]  bar0_reg;

  assign h_wide = 16'(h_next);

  always_ff @(posedge CLK_100MHz) begin
    if (RST)       bar0_reg <= '0;
    else if (tick) bar0_reg <= h_wide[8:6];
  end

  always_comb begin
    r_sel = pix_R_in;
    g_sel = pix_G_in;
    b_sel = pix_B_in;
    if (test_mode) begin
      r_sel = {4{bar0_reg[2]}};
      g_sel = {4{bar0_reg[1]}};
      b_sel = {4{bar0_reg[0]}};
    end
  end
`else
  assign r_sel = pix_R_in;
  assign g_sel = pix_G_in;
  assign b_sel = pix_B_in;
`endif

  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      div_reg     <= '0;
      h_reg       <= '0;
      v_reg       <= '0;
      pix_addr    <= '0;
      active0_reg <= 1'b0;
      hs0_reg     <= 1'b1;
      vs0_reg     <= 1'b1;
      vga_R       <= '0;
      vga_G       <= '0;
      vga_B       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
      state       <= '0;
      cur_map     <= '0;
      cur_select  <= '0;
      read_only   <= '0;
    end else begin
      div_reg     <= tick ? '0 : div_reg + 1'b1;
      frame_start <= snap_fire;
      if (tick) begin
        h_reg       <= h_next;
        v_reg       <= v_next;
        pix_addr    <= addr_next;
        active0_reg <= active_next;
        hs0_reg     <= hs_next;
        vs0_reg     <= vs_next;
        // Printer reply for the address held during the pixel period just ending.
        vga_R       <= active0_reg ? r_sel : '0;
        vga_G       <= active0_reg ? g_sel : '0;
        vga_B       <= active0_reg ? b_sel : '0;
        vga_hs      <= hs0_reg;
        vga_vs      <= vs0_reg;
      end
      if (snap_fire) begin
        state      <= game_state;
        cur_map    <= game_map;
        cur_select <= game_select;
        read_only  <= game_ro;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: tick-count reference model, random game/printer stimulus, reduced frame size.
module tb_vga_scan_ctrl;
  localparam int CD = 4;
  localparam int HA = 160, HF = 8, HS = 24, HB = 8;
  localparam int VA = 6,   VF = 2, VS = 2,  VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 200
  localparam int VT = VA + VF + VS + VB;   // 12
  localparam int FT = HT * VT;             // ticks per frame

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   game_state;
  logic [323:0] game_map;
  logic [7:0]   game_select;
  logic [80:0]  game_ro;
  logic [18:0]  pix_addr;
  logic [3:0]   state;
  logic [323:0] cur_map;
  logic [7:0]   cur_select;
  logic [80:0]  read_only;
  logic [3:0]   pix_R_in, pix_G_in, pix_B_in;
  logic [3:0]   vga_R, vga_G, vga_B;
  logic         vga_hs, vga_vs, frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic         test_mode;
`endif

  assign pix_R_in = pix_addr[3:0];

  vga_scan_ctrl #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLK_100MHz(clk), .RST(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .game_state(game_state), .game_map(game_map), .game_select(game_select), .game_ro(game_ro),
    .pix_addr(pix_addr), .state(state), .cur_map(cur_map), .cur_select(cur_select), .read_only(read_only),
    .pix_R_in(pix_R_in), .pix_G_in(pix_G_in), .pix_B_in(pix_B_in),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [323:0] a, input logic [323:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference model: everything follows from the number of pixel ticks since reset release.
  int           m_edges, m_ticks;
  logic [3:0]   m_g, m_b;
  logic [3:0]   m_state;
  logic [323:0] m_map;
  logic [7:0]   m_sel;
  logic [80:0]  m_ro;
  logic         m_fs;
`ifdef VGA_TEST_PATTERN_EN
  logic         m_tm;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_edges <= 0; m_ticks <= 0; m_g <= '0; m_b <= '0; m_fs <= 1'b0;
      m_state <= '0; m_map <= '0; m_sel <= '0; m_ro <= '0;
`ifdef VGA_TEST_PATTERN_EN
      m_tm <= 1'b0;
`endif
    end else begin
      m_edges <= m_edges + 1;
      m_fs    <= 1'b0;
      if ((m_edges + 1) % CD == 0) begin
        m_ticks <= m_ticks + 1;
        m_g <= pix_G_in;
        m_b <= pix_B_in;
`ifdef VGA_TEST_PATTERN_EN
        m_tm <= test_mode;
`endif
        if ((m_ticks + 1) % FT == VA * HT) begin
          m_state <= game_state; m_map <= game_map; m_sel <= game_select; m_ro <= game_ro;
          m_fs <= 1'b1;
        end
      end
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    int p, h, v, q, hq, vq;
    bit act;
    logic [3:0] er, eg, eb;
    logic ehs, evs;
    logic [18:0] ea;
    if (chk_on) begin
      p  = m_ticks % FT;
      h  = p % HT;
      v  = p / HT;
      ea = (h < HA && v < VA) ? 19'(v * HA + h) : 19'd0;
      er = '0; eg = '0; eb = '0; ehs = 1'b1; evs = 1'b1;
      // The first pixel after reset leaves the delay stage in its blank reset state.
      if (m_ticks >= 2) begin
        q   = (m_ticks - 1) % FT;
        hq  = q % HT;
        vq  = q / HT;
        act = (hq < HA) && (vq < VA);
        ehs = !(hq >= HA + HF && hq < HA + HF + HS);
        evs = !(vq >= VA + VF && vq < VA + VF + VS);
        if (act) begin
          er = 4'((vq * HA + hq) % 16);
          eg = m_g;
          eb = m_b;
`ifdef VGA_TEST_PATTERN_EN
          if (m_tm) begin
            er = {4{hq[8]}}; eg = {4{hq[7]}}; eb = {4{hq[6]}};
          end
`endif
        end
      end
      chk("pix_addr", pix_addr, ea);
      chk("vga_R", vga_R, er);
      chk("vga_G", vga_G, eg);
      chk("vga_B", vga_B, eb);
      chk("vga_hs", vga_hs, ehs);
      chk("vga_vs", vga_vs, evs);
      chk("frame_start", frame_start, m_fs);
      chk("state", state, m_state);
      chk("cur_map", cur_map, m_map);
      chk("cur_select", cur_select, m_sel);
      chk("read_only", read_only, m_ro);
    end
  end

  initial begin
    pix_G_in = '0;
    pix_B_in = '0;
    forever begin
      @(negedge clk);
      pix_G_in = 4'($urandom);
      pix_B_in = 4'($urandom);
    end
  end

  task automatic rand_game();
    logic [351:0] tm;
    logic [95:0]  tr;
    for (int i = 0; i < 11; i++) tm[i*32 +: 32] = $urandom;
    tr = {$urandom, $urandom, $urandom};
    game_map    = tm[323:0];
    game_ro     = tr[80:0];
    game_state  = 4'($urandom);
    game_select = 8'($urandom);
  endtask

  task automatic wait_tick(input int target);
    int n;
    n = 0;
    while (m_ticks < target && n < 50000) begin
      @(negedge clk);
      n++;
    end
    if (m_ticks < target) begin
      total++; bad++;
      $display("FAIL wait_tick: got %0d want %0d", m_ticks, target);
    end
  endtask

  int hs_low, vs_low, fs_cnt, n;
  logic [18:0] max_addr;

  initial begin
    rst = 1'b1;
    game_state = '0; game_map = '0; game_select = '0; game_ro = '0;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_addr", pix_addr, 19'd0);
      chk("rst_hs", vga_hs, 1'b1);
      chk("rst_R", vga_R, 4'd0);
    end
    @(negedge clk);
    chk("tick1_addr", pix_addr, 19'd1);

    wait_tick(HT);
    game_state = 4'd1; game_map = 324'h1; game_select = 8'd40; game_ro = 81'h155;
    wait_tick(4 * HT);
    game_select = 8'd41;
    chk("presnap_sel", cur_select, 8'd0);

    n = 0;
    while (frame_start !== 1'b1 && n < FT * CD) begin
      @(negedge clk);
      n++;
    end
    chk("snap_seen", frame_start, 1'b1);
    chk("snap_sel", cur_select, 8'd41);
    chk("snap_state", state, 4'd1);
    chk("snap_map", cur_map, 324'h1);

    // One whole frame, starting on the frame_start clock, with the game model churning every clock.
    hs_low = 0; vs_low = 0; fs_cnt = 0; max_addr = '0;
    for (int i = 0; i < FT * CD; i++) begin
      if (i > 0) @(negedge clk);
      if (vga_hs == 1'b0) hs_low++;
      if (vga_vs == 1'b0) vs_low++;
      if (frame_start) fs_cnt++;
      if (pix_addr > max_addr) max_addr = pix_addr;
      rand_game();
    end
    chk("hs_low_clks", 32'(hs_low), 32'd1152);   // 12 lines * 24 px * 4 clk
    chk("vs_low_clks", 32'(vs_low), 32'd1600);   // 2 lines * 200 px * 4 clk
    chk("fs_per_frame", 32'(fs_cnt), 32'd1);
    chk("max_addr", max_addr, 19'd959);          // 5*160 + 159

    n = 0;
    while (m_ticks % FT != 3 * HT + 100 && n < FT * CD) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_addr", pix_addr, 19'd0);
    chk("mid_rst_hs", vga_hs, 1'b1);
    chk("mid_rst_vs", vga_vs, 1'b1);
    chk("mid_rst_map", cur_map, 324'h0);
    chk("mid_rst_fs", frame_start, 1'b0);
    rst = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    wait_tick(101);
    chk("bar_B", vga_B, 4'hF);
    chk("bar_R", vga_R, 4'h0);
`endif

    for (int i = 0; i < FT * CD + 500; i++) begin
      @(negedge clk);
      if (i % 37 == 0) rand_game();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
